fsm1_obs_capture: RTL and testbench

- Downstream stage of fsm1_route. Consumes its per-window pulse outputs (output1_Pad, state_obs0_Pad, state_obs1_Pad).
- Reconstructs the 2-bit FSM state each GCLK window and accumulates statistics: per-state dwell counts, output1 pulse count and state-transition count.
- Streams a snapshot of the statistics out on a single-bit serial port on request. This gives the bench and silicon test a low-pin-count readout of fsm1 activity.

---
 rtl/fsm1_obs_pkg.sv | 28 ++
 rtl/fsm1_obs_sat_counter.sv | 23 ++
 rtl/fsm1_obs_capture.sv | 123 ++++++++++++
 tb/tb_fsm1_obs_capture.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm1_obs_pkg.sv
// Shared constants and types for the fsm1 observation/statistics block.
package fsm1_obs_pkg;

    localparam int unsigned DEF_CNT_W  = 8;
    localparam int unsigned NUM_WORDS  = 6;
    localparam int unsigned FRAME_BITS = NUM_WORDS * DEF_CNT_W;

    // Order of the statistics words inside a readout frame (word 0 goes out first).
    typedef enum logic [2:0] {
        W_DWELL0 = 3'd0,
        W_DWELL1 = 3'd1,
        W_DWELL2 = 3'd2,
        W_DWELL3 = 3'd3,
        W_OUT    = 3'd4,
        W_TRANS  = 3'd5
    } word_idx_e;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rd_state_e;

    // Bit position of the MSB of word w in a frame built from cnt_w-bit words.
    function automatic int unsigned word_msb(input int unsigned w, input int unsigned cnt_w);
        return (NUM_WORDS - w) * cnt_w - 1;
    endfunction

endpackage

// File: rtl/fsm1_obs_sat_counter.sv
// Saturating event counter with synchronous clear.
module fsm1_obs_sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    // Count up on inc, stick at all-ones, clear wins over counting.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fsm1_obs_capture.sv
// Reconstructs fsm1 state per window, keeps activity statistics and
// streams a snapshot of them out MSB-first on a serial port.
module fsm1_obs_capture
    import fsm1_obs_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic       GCLK_Pad,
    input  logic       reset_Pad,
    input  logic       output1_Pad,
    input  logic       state_obs0_Pad,
    input  logic       state_obs1_Pad,
    input  logic       rd_req_Pad,
    input  logic       clr_Pad,
    output logic [1:0] cur_state,
    output logic       busy_Pad,
    output logic       ser_out_Pad,
    output logic       ser_valid_Pad,
    output logic       frame_end_Pad
);

    localparam int unsigned FRAME_W = NUM_WORDS * CNT_W;
    localparam int unsigned IDX_W   = $clog2(FRAME_W);

    logic [1:0]           sample;
    logic                 prev_valid;
    logic [NUM_WORDS-1:0] inc;
    logic [CNT_W-1:0]     count [NUM_WORDS];
    logic [FRAME_W-1:0]   live;
    logic [FRAME_W-1:0]   snapshot;
    logic [IDX_W-1:0]     idx;
    rd_state_e            state;

    assign sample = {state_obs1_Pad, state_obs0_Pad};

    // Per-counter increment enables for this window.
    always_comb begin
        inc = '0;
        for (int unsigned d = 0; d < 4; d++) begin
            inc[d] = (sample == 2'(d));
        end
        inc[W_OUT]   = output1_Pad;
        inc[W_TRANS] = prev_valid && (sample != cur_state);
    end

    // Track the observed state; the first sample after reset has no predecessor.
    always_ff @(posedge GCLK_Pad) begin
        if (reset_Pad) begin
            cur_state  <= 2'b00;
            prev_valid <= 1'b0;
        end else begin
            cur_state  <= sample;
            prev_valid <= 1'b1;
        end
    end

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_cnt
        fsm1_obs_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (GCLK_Pad),
            .reset (reset_Pad),
            .clr   (clr_Pad),
            .inc   (inc[w]),
            .count (count[w])
        );
    end

    // Pack the live counters into frame order, dwell0 in the top word.
    always_comb begin
        live = '0;
        for (int unsigned w = 0; w < NUM_WORDS; w++) begin
            live[word_msb(w, CNT_W) -: CNT_W] = count[w];
        end
    end

    // Readout FSM: capture on request in IDLE, then shift one bit per cycle.
    always_ff @(posedge GCLK_Pad) begin
        if (reset_Pad) begin
            state         <= IDLE;
            snapshot      <= '0;
            idx           <= '0;
            busy_Pad      <= 1'b0;
            ser_out_Pad   <= 1'b0;
            ser_valid_Pad <= 1'b0;
            frame_end_Pad <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy_Pad      <= 1'b0;
                    ser_out_Pad   <= 1'b0;
                    ser_valid_Pad <= 1'b0;
                    frame_end_Pad <= 1'b0;
                    if (rd_req_Pad) begin
                        snapshot      <= live;
                        idx           <= IDX_W'(FRAME_W - 1);
                        state         <= SHIFT;
                        busy_Pad      <= 1'b1;
                        ser_valid_Pad <= 1'b1;
                        ser_out_Pad   <= live[FRAME_W-1];
                    end
                end
                SHIFT: begin
                    if (idx == '0) begin
                        state         <= IDLE;
                        busy_Pad      <= 1'b0;
                        ser_out_Pad   <= 1'b0;
                        ser_valid_Pad <= 1'b0;
                        frame_end_Pad <= 1'b0;
                    end else begin
                        idx           <= idx - IDX_W'(1);
                        ser_out_Pad   <= snapshot[idx - IDX_W'(1)];
                        frame_end_Pad <= (idx == IDX_W'(1));
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsm1_obs_capture.sv
// Randomised and directed bench for fsm1_obs_capture against a queue-based model.
module tb_fsm1_obs_capture;

    localparam int MAXC = 255;

    logic       clk = 1'b0;
    logic       rst, o1, s0, s1, rd, cl;
    logic [1:0] cur;
    logic       busy, sout, sval, fend;

    always #5 clk = ~clk;

    fsm1_obs_capture #(.CNT_W(8)) dut (
        .GCLK_Pad       (clk),
        .reset_Pad      (rst),
        .output1_Pad    (o1),
        .state_obs0_Pad (s0),
        .state_obs1_Pad (s1),
        .rd_req_Pad     (rd),
        .clr_Pad        (cl),
        .cur_state      (cur),
        .busy_Pad       (busy),
        .ser_out_Pad    (sout),
        .ser_valid_Pad  (sval),
        .frame_end_Pad  (fend)
    );

    int checks = 0;
    int errors = 0;

    // Model state: counters as plain integers, frame as a queue of pending bits.
    int  m_cnt [6];
    int  m_cur;
    bit  m_pv;
    bit  m_busy, m_out, m_val, m_end;
    bit  q [$];

    // Frame capture from the DUT's serial port.
    logic [47:0] cap, last_frame;
    int nbits, last_nbits, frames, busy_cycles;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bump(input int k);
        if (m_cnt[k] < MAXC) m_cnt[k]++;
    endtask

    task automatic model_step(input bit r, input bit o, input bit [1:0] s, input bit rdq, input bit clq);
        logic [47:0] snap;
        if (r) begin
            foreach (m_cnt[k]) m_cnt[k] = 0;
            m_cur = 0; m_pv = 0; q.delete();
            m_busy = 0; m_out = 0; m_val = 0; m_end = 0;
            return;
        end
        if (!m_busy && rdq) begin
            snap = {8'(m_cnt[0]), 8'(m_cnt[1]), 8'(m_cnt[2]), 8'(m_cnt[3]), 8'(m_cnt[4]), 8'(m_cnt[5])};
            for (int i = 47; i >= 0; i--) q.push_back(snap[i]);
        end
        if (q.size() > 0) begin
            m_out = q.pop_front(); m_val = 1; m_busy = 1; m_end = (q.size() == 0);
        end else begin
            m_out = 0; m_val = 0; m_busy = 0; m_end = 0;
        end
        if (clq) begin
            foreach (m_cnt[k]) m_cnt[k] = 0;
        end else begin
            bump(int'(s));
            if (o) bump(4);
            if (m_pv && int'(s) != m_cur) bump(5);
        end
        m_cur = int'(s);
        m_pv  = 1;
    endtask

    // One clock: drive inputs, advance model, compare after the edge, capture frame bits.
    task automatic cyc(input bit r, input bit o, input bit [1:0] s, input bit rdq, input bit clq);
        rst = r; o1 = o; {s1, s0} = s; rd = rdq; cl = clq;
        model_step(r, o, s, rdq, clq);
        @(posedge clk);
        @(negedge clk);
        check("cur_state", cur, m_cur);
        check("busy", busy, m_busy);
        check("ser_valid", sval, m_val);
        check("ser_out", sout, m_out);
        check("frame_end", fend, m_end);
        if (busy) busy_cycles++;
        if (r) nbits = 0;
        if (sval) begin
            cap = {cap[46:0], sout};
            nbits++;
            if (fend) begin
                last_frame = cap; last_nbits = nbits; nbits = 0; frames++;
            end
        end
    endtask

    task automatic wait_idle(input bit [1:0] s);
        for (int i = 0; i < 200 && (busy || m_busy); i++) cyc(0, 0, s, 0, 0);
        check("idle_timeout", busy, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 2'b00, 0, 0);
        cyc(1, 0, 2'b00, 0, 0);
    endtask

    initial begin
        int f0;
        bit [1:0] seq2 [5]  = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd0};
        bit [1:0] seq4 [10] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        cap = '0; last_frame = '0; nbits = 0; last_nbits = 0; frames = 0; busy_cycles = 0;

        // Reset state
        do_reset();
        check("rst_cur", cur, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", sval, 0);
        check("rst_fend", fend, 0);

        // Dwell in state 1 with alternating output pulses
        for (int i = 0; i < 10; i++) cyc(0, (i % 2) == 0, 2'b01, 0, 0);
        check("t1_model_dwell1", m_cnt[1], 10);
        check("t1_model_out", m_cnt[4], 5);
        check("t1_model_trans", m_cnt[5], 0);
        cyc(0, 0, 2'b01, 1, 0);
        wait_idle(2'b01);
        check("t1_frame", last_frame, 48'h000A00000500);
        check("t1_nbits", last_nbits, 48);

        // Transition counting
        do_reset();
        foreach (seq2[i]) cyc(0, 0, seq2[i], 0, 0);
        cyc(0, 0, 2'b00, 1, 0);
        wait_idle(2'b00);
        check("t2_frame", last_frame, 48'h020200010003);

        // Saturation
        do_reset();
        for (int i = 0; i < 300; i++) cyc(0, 1, 2'b00, 0, 0);
        check("t3_model_sat", m_cnt[4], 255);
        cyc(0, 0, 2'b00, 1, 0);
        wait_idle(2'b00);
        check("t3_frame", last_frame, 48'hFF000000FF00);

        // Preloaded frame, busy length, ignored mid-frame request
        do_reset();
        foreach (seq4[i]) cyc(0, i < 5, seq4[i], 0, 0);
        f0 = frames; busy_cycles = 0;
        cyc(0, 0, 2'b11, 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 2'b11, 0, 0);
        cyc(0, 0, 2'b11, 1, 0);
        wait_idle(2'b11);
        for (int i = 0; i < 5; i++) cyc(0, 0, 2'b11, 0, 0);
        check("t4_frame", last_frame, 48'h010203040506);
        check("t4_frames", frames - f0, 1);
        check("t4_busy_cycles", busy_cycles, 48);
        check("t4_fend_pos", last_nbits, 48);

        // Simultaneous read and clear, counting during the frame
        do_reset();
        for (int i = 0; i < 9; i++) cyc(0, 1, 2'b00, 0, 0);
        cyc(0, 0, 2'b00, 1, 1);
        for (int i = 0; i < 60; i++) cyc(0, (i == 5) || (i == 15) || (i == 25), 2'b00, 0, 0);
        wait_idle(2'b00);
        check("t5_frame", last_frame, 48'h090000000900);
        cyc(0, 0, 2'b00, 1, 0);
        wait_idle(2'b00);
        check("t5_out_after", last_frame[15:8], 3);

        // Reset mid-frame
        do_reset();
        for (int i = 0; i < 5; i++) cyc(0, 1, 2'b10, 0, 0);
        cyc(0, 0, 2'b10, 1, 0);
        for (int i = 0; i < 19; i++) cyc(0, 0, 2'b10, 0, 0);
        check("t6_bit20", nbits, 20);
        f0 = frames;
        cyc(1, 0, 2'b10, 0, 0);
        check("t6_valid", sval, 0);
        check("t6_busy", busy, 0);
        check("t6_fend", fend, 0);
        cyc(0, 0, 2'b00, 1, 0);
        wait_idle(2'b00);
        check("t6_frames", frames - f0, 1);
        check("t6_frame", last_frame, 48'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 200) == 0, 1'($urandom), 2'($urandom), ($urandom % 10) == 0, ($urandom % 50) == 0);
        end
        wait_idle(2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
